// File: rtl/subservient_gpio_bank.sv
// subservient_gpio_bank: WIDTH-channel GPIO slave on the subservient Wishbone port.
// Registers: 0 OUT, 1 IN, 2 OE, 3 IRQ_EN, 4 IRQ_STAT (W1C); 5..7 read as zero.
// The rising-edge interrupt logic is only built when SUBSERVIENT_GPIO_BANK_IRQ_EN
// is defined. Without it, addresses 3/4 read 0 and o_irq is tied low.
// Register fields are kept 32 bits wide, with bits >= WIDTH held at 0.
// This lets the whole data bus take part in the write path.
module subservient_gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_wb_clk,
    input  logic             i_wb_rst,
    input  logic [2:0]       i_wb_adr,
    input  logic [31:0]      i_wb_dat,
    input  logic [3:0]       i_wb_sel,
    input  logic             i_wb_we,
    input  logic             i_wb_stb,
    output logic [31:0]      o_wb_rdt,
    output logic             o_wb_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    localparam logic [31:0] WMASK = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'h1 << WIDTH) - 32'h1);

    logic                                 acc;
    logic                                 wr;
    logic [31:0]                          wm;
    logic [31:0]                          out_q;
    logic [31:0]                          oe_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0]    sync_q;
    logic [WIDTH-1:0]                     in_q;
    logic [31:0]                          in_ext;
    logic [31:0]                          rd_mux;

    // A new access is accepted only when no ack is pending, so a held stb
    // alternates ack high and low.
    assign acc = i_wb_stb & ~o_wb_ack;
    assign wr  = acc & i_wb_we;
    assign wm  = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}} & WMASK;

    assign in_q      = sync_q[SYNC_STAGES-1];
    assign o_gpio    = out_q[WIDTH-1:0];
    assign o_gpio_oe = oe_q[WIDTH-1:0];

    // Zero-extend the synchronised inputs to the bus width.
    always_comb begin
        in_ext            = '0;
        in_ext[WIDTH-1:0] = in_q;
    end

    // Input synchroniser chain. Stage 0 samples the pad, and the last stage is IN.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= i_gpio;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
        end
    end

    // OUT and OE registers: byte-enabled writes, with bits >= WIDTH masked off.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            out_q <= '0;
            oe_q  <= '0;
        end else if (wr) begin
            if (i_wb_adr == 3'd0) out_q <= (out_q & ~wm) | (i_wb_dat & wm);
            if (i_wb_adr == 3'd2) oe_q  <= (oe_q  & ~wm) | (i_wb_dat & wm);
        end
    end

`ifdef SUBSERVIENT_GPIO_BANK_IRQ_EN
    logic [31:0]      en_q;
    logic [31:0]      stat_q;
    logic [WIDTH-1:0] prev_q;
    logic [31:0]      rise_ext;
    logic [31:0]      clr;

    // Rising edges of IN, and the bits being cleared by a W1C write to IRQ_STAT.
    always_comb begin
        rise_ext            = '0;
        rise_ext[WIDTH-1:0] = in_q & ~prev_q;
        clr                 = (wr && i_wb_adr == 3'd4) ? (i_wb_dat & wm) : '0;
    end

    // Enable, status and edge-detect state. A new edge overrides a
    // same-cycle clear, and masked edges are not remembered.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            en_q   <= '0;
            stat_q <= '0;
            prev_q <= '0;
            o_irq  <= 1'b0;
        end else begin
            prev_q <= in_q;
            if (wr && i_wb_adr == 3'd3) en_q <= (en_q & ~wm) | (i_wb_dat & wm);
            stat_q <= (stat_q & ~clr) | (rise_ext & en_q);
            o_irq  <= |(stat_q & en_q);
        end
    end
`else
    assign o_irq = 1'b0;
`endif

    // Read mux. Unmapped addresses, and the IRQ pair when the IRQ logic is absent, read 0.
    always_comb begin
        rd_mux = '0;
        case (i_wb_adr)
            3'd0:    rd_mux = out_q;
            3'd1:    rd_mux = in_ext;
            3'd2:    rd_mux = oe_q;
`ifdef SUBSERVIENT_GPIO_BANK_IRQ_EN
            3'd3:    rd_mux = en_q;
            3'd4:    rd_mux = stat_q;
`endif
            default: rd_mux = '0;
        endcase
    end

    // Bus response: one-cycle ack, with read data captured on every accepted access.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            o_wb_ack <= 1'b0;
            o_wb_rdt <= '0;
        end else begin
            o_wb_ack <= acc;
            if (acc) o_wb_rdt <= rd_mux;
        end
    end

endmodule

// File: tb/tb_subservient_gpio_bank.sv
// Directed bench for subservient_gpio_bank (WIDTH=8, SYNC_STAGES=2).
// The IRQ checks follow SUBSERVIENT_GPIO_BANK_IRQ_EN, matching the DUT build.
module tb_subservient_gpio_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  adr = '0;
    logic [31:0] dat = '0;
    logic [3:0]  sel = '0;
    logic        we  = 1'b0;
    logic        stb = 1'b0;
    logic [31:0] rdt;
    logic        ack;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic [7:0]  gpio_oe;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    subservient_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .i_wb_clk  (clk),
        .i_wb_rst  (rst),
        .i_wb_adr  (adr),
        .i_wb_dat  (dat),
        .i_wb_sel  (sel),
        .i_wb_we   (we),
        .i_wb_stb  (stb),
        .o_wb_rdt  (rdt),
        .o_wb_ack  (ack),
        .i_gpio    (gpio_in),
        .o_gpio    (gpio_out),
        .o_gpio_oe (gpio_oe),
        .o_irq     (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus access, started at a falling edge. Returns the read data and the
    // number of edges until ack (0 means no ack arrived).
    task automatic wb_acc(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, output logic [31:0] r, output int lat);
        @(negedge clk);
        adr = a; dat = d; sel = s; we = w; stb = 1'b1;
        lat = 0;
        r   = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) chk("ack_timeout", 32'(lat), 32'd1);
        r = rdt;
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        int          lat;
        wb_acc(a, d, s, 1'b1, r, lat);
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int          lat;
        wb_acc(a, 32'h0, 4'h0, 1'b0, r, lat);
        chk(tag, r, exp);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_gpio", 32'(gpio_out), 32'h0);
        chk("rst_oe",   32'(gpio_oe),  32'h0);
        chk("rst_ack",  32'(ack),      32'h0);
        chk("rst_rdt",  rdt,           32'h0);
        chk("rst_irq",  32'(irq),      32'h0);

        // Read every address after reset: all zero, one-cycle ack latency and width
        for (int a = 0; a < 8; a++) begin
            wb_acc(3'(a), 32'h0, 4'h0, 1'b0, r, lat);
            chk($sformatf("rd0_a%0d", a), r, 32'h0);
            chk($sformatf("lat_a%0d", a), 32'(lat), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("ack_drop_a%0d", a), 32'(ack), 32'h0);
        end

        // OUT/OE writes, byte enables and WIDTH masking
        wr(3'd0, 32'h0000_00A5, 4'hF);
        chk("out_wr", 32'(gpio_out), 32'hA5);
        wr(3'd2, 32'h0000_000F, 4'h1);
        chk("oe_wr", 32'(gpio_oe), 32'h0F);
        rd_chk("out_rb", 3'd0, 32'hA5);
        rd_chk("oe_rb",  3'd2, 32'h0F);
        wr(3'd0, 32'hFFFF_FF00, 4'h2);
        chk("out_hi_ign", 32'(gpio_out), 32'hA5);
        rd_chk("out_rb2", 3'd0, 32'hA5);
        wr(3'd2, 32'h0000_00F0, 4'h0);
        chk("oe_sel0", 32'(gpio_oe), 32'h0F);
        wr(3'd0, 32'h0000_003C, 4'hE);
        chk("out_sel_hi", 32'(gpio_out), 32'hA5);
        wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        rd_chk("a7_ign", 3'd7, 32'h0);
        wr(3'd5, 32'hFFFF_FFFF, 4'hF);
        rd_chk("a5_ign", 3'd5, 32'h0);
        chk("out_after_unmapped", 32'(gpio_out), 32'hA5);

        // IN latency. The pad changes just before edge 1, so a read at edge 1
        // sees 0 and a read at edge 3 sees the new value.
        @(negedge clk);
        gpio_in = 8'h3C;
        adr = 3'd1; we = 1'b0; stb = 1'b1;
        @(posedge clk); #1;
        chk("in_e1_ack", 32'(ack), 32'h1);
        chk("in_e1", rdt, 32'h00);
        @(posedge clk); #1;
        chk("in_e2_ack", 32'(ack), 32'h0);
        @(posedge clk); #1;
        chk("in_e3_ack", 32'(ack), 32'h1);
        chk("in_e3", rdt, 32'h3C);
        @(negedge clk);
        stb = 1'b0;
        // Pad change before edge 1, read at edge 2 (old value), read again at edge 4
        @(negedge clk);
        gpio_in = 8'h5A;
        @(negedge clk);
        stb = 1'b1;
        @(posedge clk); #1;
        chk("in_e2_old", rdt, 32'h3C);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("in_e4_new", rdt, 32'h5A);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);

        // Held stb: ack toggles 0,1,0,1,0,1
        stb = 1'b1; adr = 3'd0; we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("ack_pat%0d", i), 32'(ack), 32'(i % 2));
            @(negedge clk);
        end
        stb = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset during the ack-pending cycle of a write: access dropped, OUT back to 0
        adr = 3'd0; dat = 32'h0000_00FF; sel = 4'hF; we = 1'b1; stb = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ack", 32'(ack), 32'h0);
        chk("rst_mid_out", 32'(gpio_out), 32'h0);
        @(negedge clk);
        stb = 1'b0; we = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_ack2", 32'(ack), 32'h0);
        chk("rst_mid_out2", 32'(gpio_out), 32'h0);

        gpio_in = 8'h00;
        repeat (5) @(negedge clk);

`ifdef SUBSERVIENT_GPIO_BANK_IRQ_EN
        wr(3'd3, 32'h0000_0001, 4'h1);
        rd_chk("en_rb", 3'd3, 32'h01);
        @(negedge clk);
        gpio_in = 8'h01;
        repeat (6) @(negedge clk);
        rd_chk("stat_set", 3'd4, 32'h01);
        chk("irq_set", 32'(irq), 32'h1);
        wr(3'd4, 32'h0000_0001, 4'h1);
        @(posedge clk); #1;
        chk("irq_clr", 32'(irq), 32'h0);
        rd_chk("stat_clr", 3'd4, 32'h00);
        // Masked edge on bit 1 is lost
        @(negedge clk);
        gpio_in = 8'h03;
        repeat (6) @(negedge clk);
        rd_chk("stat_masked", 3'd4, 32'h00);
        chk("irq_masked", 32'(irq), 32'h0);
        // Edge on bit 0 lands on the same edge as a W1C of bit 0: set wins
        gpio_in = 8'h00;
        repeat (6) @(negedge clk);
        gpio_in = 8'h01;
        @(negedge clk);
        @(negedge clk);
        adr = 3'd4; dat = 32'h0000_0001; sel = 4'h1; we = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        chk("sw_ack", 32'(ack), 32'h1);
        @(negedge clk);
        stb = 1'b0; we = 1'b0;
        rd_chk("set_wins", 3'd4, 32'h01);
        chk("set_wins_irq", 32'(irq), 32'h1);
        // Clearing EN drops o_irq but leaves STAT set
        wr(3'd3, 32'h0000_0000, 4'h1);
        @(posedge clk); #1;
        chk("en_off_irq", 32'(irq), 32'h0);
        rd_chk("en_off_stat", 3'd4, 32'h01);
`else
        wr(3'd3, 32'hFFFF_FFFF, 4'hF);
        wr(3'd4, 32'hFFFF_FFFF, 4'hF);
        rd_chk("a3_noirq", 3'd3, 32'h0);
        rd_chk("a4_noirq", 3'd4, 32'h0);
        @(negedge clk);
        gpio_in = 8'hFF;
        repeat (6) @(negedge clk);
        chk("irq_tied", 32'(irq), 32'h0);
        rd_chk("in_ff", 3'd1, 32'hFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
